// File: rtl/systolic_pkg.sv
// Shared types, widths and the int8 saturation helper for the 16x16 systolic
// matrix-vector multiplier.
package systolic_pkg;

    localparam int MATRIX_SIZE = 16;
    localparam int DATA_W      = 8;
    localparam int PROD_W      = 16;
    localparam int ACC_W       = 20;
    localparam int SAT_MAX     = 127;
    localparam int SAT_MIN     = -128;

    typedef logic signed [DATA_W-1:0] elem_t;
    typedef logic signed [PROD_W-1:0] prod_t;
    typedef logic signed [ACC_W-1:0]  acc_t;

    function automatic elem_t sat8(input acc_t v);
        if (v > acc_t'(SAT_MAX)) return elem_t'(SAT_MAX);
        if (v < acc_t'(SAT_MIN)) return elem_t'(SAT_MIN);
        return elem_t'(v[DATA_W-1:0]);
    endfunction

endpackage

// File: rtl/dot_product_row16.sv
// One output lane: 16 registered products, 4 registered partial sums, then a
// saturated int8 result register.
module dot_product_row16
    import systolic_pkg::*;
(
    input  logic  clk,
    input  logic  reset,
    input  elem_t a [0:MATRIX_SIZE-1],
    input  elem_t b [0:MATRIX_SIZE-1],
    output elem_t c
);

    localparam int GROUP_SIZE = 4;
    localparam int GROUPS     = MATRIX_SIZE / GROUP_SIZE;

    prod_t prod_q [0:MATRIX_SIZE-1];
    acc_t  part_d [0:GROUPS-1];
    acc_t  part_q [0:GROUPS-1];
    acc_t  total_d;

    // NOTE: combinational sums use blocking '=' with a default first so each
    // running total is read back within the same evaluation and no latch forms.
    always_comb begin
        for (int g = 0; g < GROUPS; g++) begin
            part_d[g] = '0;
            for (int k = 0; k < GROUP_SIZE; k++) begin
                part_d[g] = part_d[g] + acc_t'(prod_q[g*GROUP_SIZE + k]);
            end
        end
        total_d = '0;
        for (int g = 0; g < GROUPS; g++) begin
            total_d = total_d + part_q[g];
        end
    end

    // NOTE: every pipeline register is cleared by reset so a flush drains zeros;
    // state uses non-blocking '<=' so all stages advance on the same edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int j = 0; j < MATRIX_SIZE; j++) prod_q[j] <= '0;
            for (int g = 0; g < GROUPS; g++)      part_q[g] <= '0;
            c <= '0;
        end else begin
            for (int j = 0; j < MATRIX_SIZE; j++) prod_q[j] <= prod_t'(a[j]) * prod_t'(b[j]);
            for (int g = 0; g < GROUPS; g++)      part_q[g] <= part_d[g];
            c <= sat8(total_d);
        end
    end

endmodule

// File: rtl/systolic_array_16x16.sv
// Free-running 16x16 int8 matrix-vector multiplier: sixteen lockstep
// dot-product lanes, three-edge latency, one A/B pair accepted per cycle.
module systolic_array_16x16
    import systolic_pkg::*;
(
    input  logic  clk,
    input  logic  reset,
    input  elem_t A [0:MATRIX_SIZE-1][0:MATRIX_SIZE-1],
    input  elem_t B [0:MATRIX_SIZE-1],
    output elem_t C [0:MATRIX_SIZE-1]
);

    for (genvar i = 0; i < MATRIX_SIZE; i++) begin : g_row
        dot_product_row16 u_row (
            .clk   (clk),
            .reset (reset),
            .a     (A[i]),
            .b     (B),
            .c     (C[i])
        );
    end

endmodule

// File: tb/tb_systolic_array_16x16.sv
// Scoreboard bench: each driven cycle pushes its expected C vector; the vector
// is popped and compared per lane once it emerges three edges later.
module tb_systolic_array_16x16;
    import systolic_pkg::*;

    typedef logic [MATRIX_SIZE*DATA_W-1:0] vec_t;

    logic  clk;
    logic  reset;
    elem_t A [0:MATRIX_SIZE-1][0:MATRIX_SIZE-1];
    elem_t B [0:MATRIX_SIZE-1];
    elem_t C [0:MATRIX_SIZE-1];

    int    vectors_applied = 0;
    int    miscompares     = 0;
    vec_t  exp_q [$];
    string phase = "init";

    systolic_array_16x16 dut (
        .clk   (clk),
        .reset (reset),
        .A     (A),
        .B     (B),
        .C     (C)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input int got, input int exp);
        vectors_applied++;
        if (got != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Reference: full-width signed sum, then clamp to int8.
    function automatic vec_t golden();
        vec_t v;
        for (int i = 0; i < MATRIX_SIZE; i++) begin
            int sum = 0;
            for (int j = 0; j < MATRIX_SIZE; j++) sum += int'(A[i][j]) * int'(B[j]);
            if (sum > 127) sum = 127;
            if (sum < -128) sum = -128;
            v[i*DATA_W +: DATA_W] = sum[DATA_W-1:0];
        end
        return v;
    endfunction

    task automatic step(input logic rst);
        vec_t e;
        reset = rst;
        if (rst) begin
            // A reset flushes everything still in flight.
            for (int k = 0; k < exp_q.size(); k++) exp_q[k] = '0;
            e = '0;
        end else begin
            e = golden();
        end
        exp_q.push_back(e);
        @(posedge clk);
        @(negedge clk);
        if (exp_q.size() >= 3) begin
            e = exp_q.pop_front();
            for (int i = 0; i < MATRIX_SIZE; i++)
                check($sformatf("%s c[%0d]", phase, i), int'(C[i]), int'(elem_t'(e[i*DATA_W +: DATA_W])));
        end else begin
            check({phase, " scoreboard_depth"}, exp_q.size(), 3);
        end
    endtask

    task automatic hold(input int n);
        for (int k = 0; k < n; k++) step(1'b0);
    endtask

    task automatic set_identity();
        for (int i = 0; i < MATRIX_SIZE; i++)
            for (int j = 0; j < MATRIX_SIZE; j++) A[i][j] = (i == j) ? 8'sd1 : 8'sd0;
    endtask

    task automatic fill_a(input int val);
        for (int i = 0; i < MATRIX_SIZE; i++)
            for (int j = 0; j < MATRIX_SIZE; j++) A[i][j] = elem_t'(val);
    endtask

    task automatic fill_b(input int val);
        for (int j = 0; j < MATRIX_SIZE; j++) B[j] = elem_t'(val);
    endtask

    task automatic ramp_b();
        for (int j = 0; j < MATRIX_SIZE; j++) B[j] = elem_t'(j + 1);
    endtask

    initial begin
        reset = 1'b1;
        set_identity();
        ramp_b();
        // Two flushed slots stand in for what is in flight at the first reset.
        exp_q.push_back('0);
        exp_q.push_back('0);

        phase = "identity";
        step(1'b1);
        hold(13);

        phase = "mixed_sign";
        for (int i = 0; i < MATRIX_SIZE; i++)
            for (int j = 0; j < MATRIX_SIZE; j++) A[i][j] = (j % 2 == 0) ? 8'sd1 : -8'sd1;
        ramp_b();
        hold(4);

        phase = "sat_pos";
        fill_a(127);  fill_b(127);  hold(4);
        phase = "sat_neg";
        fill_a(-128); fill_b(127);  hold(4);
        phase = "sat_negneg";
        fill_a(-128); fill_b(-128); hold(4);

        phase = "stream";
        set_identity();
        ramp_b();
        step(1'b0);
        fill_b(2);
        hold(4);

        phase = "mid_reset";
        ramp_b();
        hold(4);
        step(1'b1);
        hold(5);

        phase = "row_indep";
        fill_a(0);
        for (int j = 0; j < MATRIX_SIZE; j++) A[5][j] = 8'sd1;
        fill_b(3);
        hold(4);

        phase = "random";
        for (int k = 0; k < 20; k++) begin
            for (int i = 0; i < MATRIX_SIZE; i++)
                for (int j = 0; j < MATRIX_SIZE; j++) A[i][j] = elem_t'($urandom_range(255, 0));
            for (int j = 0; j < MATRIX_SIZE; j++)
                B[j] = (k % 2 == 0) ? elem_t'($urandom_range(255, 0)) : elem_t'($urandom_range(7, 0) - 3);
            step(1'b0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors_applied, miscompares);
        $finish;
    end

endmodule
